// File: rtl/cv32e40p_x_wb_arb.sv
// Register-file write-port arbiter between core writeback and x-interface
// results, with a small result FIFO and starvation-driven core stall.
module cv32e40p_x_wb_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_we_i,
    input  logic [4:0]  core_waddr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_stall_o,
    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic [3:0]  x_result_id_i,
    input  logic [4:0]  x_result_rd_i,
    input  logic [31:0] x_result_data_i,
    input  logic        x_result_we_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        sb_clr_valid_o,
    output logic [4:0]  sb_clr_addr_o,
    output logic [31:0] x_pending_o,
    output logic        x_buf_empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] S_MAX    = SW'(STARVE_LIMIT);
    localparam logic [PW-1:0] P_LAST   = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        G_NONE,
        G_CORE,
        G_POP,
        G_BYP
    } grant_e;

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [3:0]       r_id   [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;

    logic        w_empty;
    logic        w_ready;
    logic        w_stall;
    logic        w_xfer;
    logic        w_xwr;
    logic        w_pop;
    logic        w_push;
    grant_e      w_grant;
    logic [31:0] w_pend;
    logic [3:0]  w_unused_id;

    assign w_empty = (r_count == '0);
    assign w_ready = (r_count != FULL_CNT);
    assign w_stall = (r_starve == S_MAX) & ~w_empty;
    assign w_xfer  = x_result_valid_i & w_ready;
    // Results without a real destination are retired in the handshake cycle
    assign w_xwr   = w_xfer & x_result_we_i & (x_result_rd_i != 5'd0);

    always_comb begin
        w_grant = G_NONE;
        if (w_stall) begin
            w_grant = G_POP;
        end else if (core_we_i) begin
            w_grant = G_CORE;
        end else if (!w_empty) begin
            w_grant = G_POP;
        end else if (w_xwr) begin
            w_grant = G_BYP;
        end
    end

    assign w_pop  = (w_grant == G_POP);
    assign w_push = w_xwr & (w_grant != G_BYP);

    always_comb begin
        rf_we_o        = 1'b0;
        rf_waddr_o     = 5'd0;
        rf_wdata_o     = 32'd0;
        sb_clr_valid_o = 1'b0;
        sb_clr_addr_o  = 5'd0;
        unique case (w_grant)
            G_CORE: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = core_waddr_i;
                rf_wdata_o = core_wdata_i;
            end
            G_POP: begin
                rf_we_o        = 1'b1;
                rf_waddr_o     = r_rd[r_rptr];
                rf_wdata_o     = r_data[r_rptr];
                sb_clr_valid_o = 1'b1;
                sb_clr_addr_o  = r_rd[r_rptr];
            end
            G_BYP: begin
                rf_we_o        = 1'b1;
                rf_waddr_o     = x_result_rd_i;
                rf_wdata_o     = x_result_data_i;
                sb_clr_valid_o = 1'b1;
                sb_clr_addr_o  = x_result_rd_i;
            end
            default: begin
                rf_we_o = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pend[r_rd[i]] = 1'b1;
            end
        end
        w_pend[0] = 1'b0;
    end

    // Result id is kept alongside each entry for trace tooling only
    assign w_unused_id = r_id[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= 5'd0;
                r_data[i] <= 32'd0;
                r_id[i]   <= 4'd0;
            end
            r_vld    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= (r_rptr == P_LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_push) begin
                r_vld[r_wptr]  <= 1'b1;
                r_rd[r_wptr]   <= x_result_rd_i;
                r_data[r_wptr] <= x_result_data_i;
                r_id[r_wptr]   <= x_result_id_i;
                r_wptr         <= (r_wptr == P_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (w_grant == G_CORE && r_starve != S_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign core_stall_o     = w_stall;
    assign x_result_ready_o = w_ready;
    assign x_pending_o      = w_pend;
    assign x_buf_empty_o    = w_empty;

endmodule

// File: tb/tb_cv32e40p_x_wb_arb.sv
// Random and directed stimulus for cv32e40p_x_wb_arb, checked against
// a queue-based reference of the write-port arbitration rules.
module tb_cv32e40p_x_wb_arb;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        core_we;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        x_valid;
    logic        x_ready;
    logic [3:0]  x_id;
    logic [4:0]  x_rd;
    logic [31:0] x_data;
    logic        x_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_valid;
    logic [4:0]  sb_addr;
    logic [31:0] x_pend;
    logic        x_empty;

    int n_chk  = 0;
    int n_fail = 0;

    int          q_rd[$];
    logic [31:0] q_dat[$];
    int          m_starve;

    cv32e40p_x_wb_arb #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .core_we_i        (core_we),
        .core_waddr_i     (core_waddr),
        .core_wdata_i     (core_wdata),
        .core_stall_o     (core_stall),
        .x_result_valid_i (x_valid),
        .x_result_ready_o (x_ready),
        .x_result_id_i    (x_id),
        .x_result_rd_i    (x_rd),
        .x_result_data_i  (x_data),
        .x_result_we_i    (x_we),
        .rf_we_o          (rf_we),
        .rf_waddr_o       (rf_waddr),
        .rf_wdata_o       (rf_wdata),
        .sb_clr_valid_o   (sb_valid),
        .sb_clr_addr_o    (sb_addr),
        .x_pending_o      (x_pend),
        .x_buf_empty_o    (x_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit m_stall();
        return (m_starve == LIMIT) && (q_rd.size() != 0);
    endfunction

    task automatic step(input logic cwe, input logic [4:0] ca,
                        input logic [31:0] cd, input logic xv,
                        input logic xwe, input logic [4:0] xrd,
                        input logic [31:0] xd);
        bit          e_empty, e_ready, e_stall, xwr, e_we, e_sb, pop, byp;
        bit          core_win;
        int          e_addr;
        logic [31:0] e_data, e_pend;
        @(negedge clk);
        core_we    = cwe;
        core_waddr = ca;
        core_wdata = cd;
        x_valid    = xv;
        x_we       = xwe;
        x_rd       = xrd;
        x_data     = xd;
        x_id       = 4'($urandom);
        #1;
        e_empty  = (q_rd.size() == 0);
        e_ready  = (q_rd.size() < DEPTH);
        e_stall  = m_stall();
        xwr      = xv && e_ready && xwe && (xrd != 0);
        pop      = 0;
        byp      = 0;
        core_win = 0;
        e_we     = 0;
        e_sb     = 0;
        e_addr   = 0;
        e_data   = 0;
        if (e_stall || (!cwe && !e_empty)) begin
            pop    = 1;
            e_we   = 1;
            e_sb   = 1;
            e_addr = q_rd[0];
            e_data = q_dat[0];
        end else if (cwe) begin
            core_win = 1;
            e_we     = 1;
            e_addr   = ca;
            e_data   = cd;
        end else if (xwr) begin
            byp    = 1;
            e_we   = 1;
            e_sb   = 1;
            e_addr = xrd;
            e_data = xd;
        end
        e_pend = 0;
        foreach (q_rd[i]) e_pend |= (32'd1 << q_rd[i]);
        e_pend[0] = 1'b0;
        chk("ready", 32'(x_ready), 32'(e_ready));
        chk("stall", 32'(core_stall), 32'(e_stall));
        chk("empty", 32'(x_empty), 32'(e_empty));
        chk("pend", x_pend, e_pend);
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("sb_vld", 32'(sb_valid), 32'(e_sb));
        if (e_we) begin
            chk("rf_addr", 32'(rf_waddr), 32'(e_addr));
            chk("rf_data", rf_wdata, e_data);
        end
        if (e_sb) chk("sb_addr", 32'(sb_addr), 32'(e_addr));
        if (pop || e_empty) m_starve = 0;
        else if (core_win && m_starve < LIMIT) m_starve++;
        if (pop) begin
            void'(q_rd.pop_front());
            void'(q_dat.pop_front());
        end
        if (xwr && !byp) begin
            q_rd.push_back(xrd);
            q_dat.push_back(xd);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    logic        r_cwe;
    logic [4:0]  r_ca;
    logic [31:0] r_cd;

    initial begin
        rst_n = 1'b0;
        core_we = 0; core_waddr = 0; core_wdata = 0;
        x_valid = 0; x_id = 0; x_rd = 0; x_data = 0; x_we = 0;
        m_starve = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(x_ready), 32'd1);
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_rfwe", 32'(rf_we), 32'd0);
        chk("rst_sb", 32'(sb_valid), 32'd0);
        chk("rst_pend", x_pend, 32'd0);
        chk("rst_empty", 32'(x_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // zero-latency bypass on idle core
        step(0, 0, 0, 1, 1, 5'd5, 32'hA5A5_0001);
        chk("byp_addr", 32'(rf_waddr), 32'd5);
        chk("byp_sbaddr", 32'(sb_addr), 32'd5);
        idle();

        // core holds port while two results buffer, then drain in order
        step(1, 5'd3, 32'h33, 1, 1, 5'd6, 32'h6666);
        step(1, 5'd3, 32'h33, 1, 1, 5'd7, 32'h7777);
        step(1, 5'd3, 32'h33, 0, 0, 0, 0);
        chk("pend_c0", x_pend, 32'h0000_00C0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain6", 32'(rf_waddr), 32'd6);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain7", 32'(rf_waddr), 32'd7);
        idle();

        // full buffer under continuous core writes: starvation stalls
        step(1, 5'd3, 32'h33, 1, 1, 5'd6, 32'h6006);
        step(1, 5'd3, 32'h33, 1, 1, 5'd7, 32'h7007);
        repeat (12) step(1, 5'd3, 32'h33, 0, 0, 0, 0);
        repeat (3) idle();

        // non-writing results: handshake only
        step(0, 0, 0, 1, 0, 5'd9, 32'h1);
        step(0, 0, 0, 1, 1, 5'd0, 32'h2);

        // full buffer pops while a new result waits on ready
        step(1, 5'd2, 32'h22, 1, 1, 5'd10, 32'hA);
        step(1, 5'd2, 32'h22, 1, 1, 5'd11, 32'hB);
        step(0, 0, 0, 1, 1, 5'd12, 32'hC);
        step(0, 0, 0, 1, 1, 5'd12, 32'hC);
        repeat (4) idle();

        // reset with two buffered entries
        step(1, 5'd4, 32'h44, 1, 1, 5'd9, 32'h9);
        step(1, 5'd4, 32'h44, 1, 1, 5'd13, 32'hD);
        @(negedge clk);
        core_we = 0;
        x_valid = 0;
        rst_n   = 1'b0;
        #1;
        chk("mrst_ready", 32'(x_ready), 32'd1);
        chk("mrst_pend", x_pend, 32'd0);
        chk("mrst_empty", 32'(x_empty), 32'd1);
        q_rd.delete();
        q_dat.delete();
        m_starve = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle();

        // random traffic; core inputs held while stalled
        r_cwe = 0; r_ca = 0; r_cd = 0;
        for (int n = 0; n < 600; n++) begin
            if (!m_stall()) begin
                r_cwe = ($urandom_range(0, 99) < 65);
                r_ca  = 5'($urandom_range(1, 31));
                r_cd  = $urandom;
            end
            step(r_cwe, r_ca, r_cd,
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 9) != 0),
                 5'($urandom_range(0, 31)),
                 $urandom);
        end
        repeat (8) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
